// File: rtl/store_merge_unit_if.sv
// ---------------------------------------------------------------------------
// store_merge_unit_if
//  Bundles the pipeline-side store request handshake and the data-memory
//  port of store_merge_unit.
//  slave  : the store merge unit's view (accepts requests, drives memory)
//  master : the pipeline/memory environment's view
// Signals
//  req_valid/req_ready      store request handshake
//  req_addr/req_size/req_data  byte address, size code (00 b, 01 h, 10 w), data
//  mem_addr                 word address to data memory
//  mem_rd_en/mem_rdata      read strobe, data returned one cycle later
//  mem_wr_en/mem_wdata      write strobe and full word to write
//  done/misalign            completion pulse, rejection flag valid with done
// ---------------------------------------------------------------------------
interface store_merge_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_data;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              misalign;

    modport slave (
        input  req_valid, req_addr, req_size, req_data, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, misalign
    );

    modport master (
        output req_valid, req_addr, req_size, req_data, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, misalign
    );
endinterface

// File: rtl/store_merge_unit.sv
// ---------------------------------------------------------------------------
// store_merge_unit
//  MEM-stage store path into word-addressed data memory. Word stores are
//  written directly; byte/half stores read the target word, replace one lane
//  and write it back. Misaligned or illegal requests finish with misalign
//  and never touch memory.
// Ports
//  Clk    system clock, rising edge
//  Reset  synchronous, active-high; aborts any store in flight
//  bus    store_merge_unit_if.slave (request handshake + memory port)
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | ready for a request
//  RD     | read strobe to target word is on the bus
//  WAIT   | read data returns; merge the new lane into it
//  WR     | write strobe + done pulse
//  ERR    | done + misalign pulse, no memory access
// ---------------------------------------------------------------------------
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    store_merge_unit_if.slave     bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              mem_rd_en_q;
    logic              mem_wr_en_q;
    logic              done_q;
    logic              misalign_q;

    // Only the lane select, byte/half choice and low data bits are needed
    // after acceptance; the word address already lives in mem_addr_q.
    logic [1:0]        lane_q;
    logic              is_byte_q;
    logic [15:0]       lane_data_q;

    logic              illegal;
    logic [31:0]       merged;

    always_comb begin
        illegal = 1'b0;
        case (bus.req_size)
            SZ_BYTE: illegal = 1'b0;
            SZ_HALF: illegal = bus.req_addr[0];
            SZ_WORD: illegal = (bus.req_addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        merged = bus.mem_rdata;
        if (is_byte_q) begin
            case (lane_q)
                2'd0:    merged[7:0]   = lane_data_q[7:0];
                2'd1:    merged[15:8]  = lane_data_q[7:0];
                2'd2:    merged[23:16] = lane_data_q[7:0];
                default: merged[31:24] = lane_data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = lane_data_q;
        end else begin
            merged[15:0] = lane_data_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            lane_q      <= '0;
            is_byte_q   <= 1'b0;
            lane_data_q <= '0;
        end else begin
            // Strobes are single-cycle; each state re-asserts what it needs.
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lane_q      <= bus.req_addr[1:0];
                        is_byte_q   <= (bus.req_size == SZ_BYTE);
                        lane_data_q <= bus.req_data[15:0];
                        if (illegal) begin
                            state      <= S_ERR;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else if (bus.req_size == SZ_WORD) begin
                            state       <= S_WR;
                            mem_addr_q  <= bus.req_addr[ADDR_W-1:2];
                            mem_wdata_q <= bus.req_data;
                            mem_wr_en_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            state       <= S_RD;
                            mem_addr_q  <= bus.req_addr[ADDR_W-1:2];
                            mem_rd_en_q <= 1'b1;
                        end
                    end
                end
                S_RD: state <= S_WAIT;
                S_WAIT: begin
                    // mem_addr_q still points at the word that was read.
                    state       <= S_WR;
                    mem_wdata_q <= merged;
                    mem_wr_en_q <= 1'b1;
                    done_q      <= 1'b1;
                end
                S_WR:    state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE) && !Reset;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_wr_en = mem_wr_en_q;
    assign bus.done      = done_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// ---------------------------------------------------------------------------
// tb_store_merge_unit
//  Directed stimulus for store_merge_unit with a transaction-level model:
//  each accepted request is turned into expected strobe events at fixed
//  cycle offsets, a reference memory supplies merge results, and every
//  cycle the DUT outputs are compared with the model. Literal expectations
//  taken from hand calculation pin the model's merge results.
// ---------------------------------------------------------------------------
module tb_store_merge_unit;
    localparam int ADDR_W = 32;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    store_merge_unit_if #(.ADDR_W(ADDR_W)) bus ();

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Data memory seen by the DUT, with a preset port for the stimulus.
    logic [31:0] tb_mem [64];
    logic        pre_en  = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge Clk) begin
        if (pre_en)
            tb_mem[pre_idx] <= pre_val;
        else if (bus.mem_wr_en)
            tb_mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        if (bus.mem_rd_en)
            bus.mem_rdata <= tb_mem[bus.mem_addr[5:0]];
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          rst;
        bit          rd;
        bit          wr;
        bit          dn;
        bit          mis;
        logic [29:0] addr;
        logic [31:0] data;
        int          epoch;
    } ev_t;

    ev_t         ev [int];
    logic [31:0] model_mem [64];
    int          cyc        = 0;
    int          epoch      = 0;
    int          busy_until = 0;
    logic [29:0] exp_addr   = '0;
    logic [31:0] exp_wdata  = '0;

    function automatic bit model_legal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return lo[0] == 1'b0;
            2'd2:    return lo == 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] size,
                                                input logic [1:0] lo, input logic [31:0] d);
        int          sh;
        logic [31:0] mask;
        logic [31:0] ins;
        if (size == 2'd0) begin
            sh   = 8 * int'(lo);
            mask = 32'h0000_00FF << sh;
            ins  = (d & 32'h0000_00FF) << sh;
        end else begin
            sh   = 16 * int'(lo[1]);
            mask = 32'h0000_FFFF << sh;
            ins  = (d & 32'h0000_FFFF) << sh;
        end
        return (old & ~mask) | ins;
    endfunction

    initial begin : model
        ev_t         e;
        ev_t         blank;
        bit          s_rst;
        bit          s_acc;
        logic [31:0] s_addr;
        logic [1:0]  s_size;
        logic [31:0] s_data;
        logic [29:0] wa;
        blank = '{rst: 0, rd: 0, wr: 0, dn: 0, mis: 0, addr: '0, data: '0, epoch: 0};
        forever begin
            @(negedge Clk);
            if (cyc >= 1) begin
                e = blank;
                if (ev.exists(cyc)) begin
                    if (ev[cyc].epoch == epoch) e = ev[cyc];
                    ev.delete(cyc);
                end
                if (e.rst) begin
                    exp_addr  = '0;
                    exp_wdata = '0;
                end
                if (e.rd || e.wr) exp_addr = e.addr;
                if (e.wr) begin
                    exp_wdata = e.data;
                    model_mem[e.addr[5:0]] = e.data;
                end
                check("rd_en",     {31'd0, bus.mem_rd_en}, {31'd0, e.rd});
                check("wr_en",     {31'd0, bus.mem_wr_en}, {31'd0, e.wr});
                check("done",      {31'd0, bus.done},      {31'd0, e.dn});
                check("misalign",  {31'd0, bus.misalign},  {31'd0, e.mis});
                check("mem_addr",  {2'd0, bus.mem_addr},   {2'd0, exp_addr});
                check("mem_wdata", bus.mem_wdata,          exp_wdata);
                check("req_ready", {31'd0, bus.req_ready},
                      {31'd0, (!Reset && cyc > busy_until)});
            end
            s_rst  = Reset;
            s_acc  = bus.req_valid && bus.req_ready;
            s_addr = bus.req_addr;
            s_size = bus.req_size;
            s_data = bus.req_data;
            @(posedge Clk);
            cyc++;
            if (pre_en) model_mem[pre_idx] = pre_val;
            if (s_rst) begin
                epoch++;
                e          = blank;
                e.rst      = 1'b1;
                e.epoch    = epoch;
                ev[cyc]    = e;
                busy_until = cyc - 1;
            end else if (s_acc) begin
                wa = s_addr[31:2];
                if (!model_legal(s_size, s_addr[1:0])) begin
                    e = blank; e.dn = 1; e.mis = 1; e.epoch = epoch;
                    ev[cyc]    = e;
                    busy_until = cyc;
                end else if (s_size == 2'd2) begin
                    e = blank; e.wr = 1; e.dn = 1; e.addr = wa; e.data = s_data; e.epoch = epoch;
                    ev[cyc]    = e;
                    busy_until = cyc;
                end else begin
                    e = blank; e.rd = 1; e.addr = wa; e.epoch = epoch;
                    ev[cyc] = e;
                    e = blank; e.wr = 1; e.dn = 1; e.addr = wa; e.epoch = epoch;
                    e.data = model_merge(model_mem[wa[5:0]], s_size, s_addr[1:0], s_data);
                    ev[cyc + 2] = e;
                    busy_until  = cyc + 2;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic preset(input int idx, input logic [31:0] val);
        @(negedge Clk);
        pre_en  = 1'b1;
        pre_idx = idx[5:0];
        pre_val = val;
        @(posedge Clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input bit hold);
        int n;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_size  = s;
        bus.req_data  = d;
        n = 0;
        @(negedge Clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("accept_within_budget", {31'd0, (n < 50)}, 32'd1);
        @(posedge Clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; latency counts edges.
    task automatic wait_done(input int exp_lat, input bit exp_mis);
        int lat;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("done_misalign", {31'd0, bus.misalign}, {31'd0, exp_mis});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_mem_addr",  {2'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_strobes",   {28'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign}, 32'd0);
        check("rst_ready_low", {31'd0, bus.req_ready}, 32'd0);
        Reset = 1'b0;
        #1 check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
        for (int i = 0; i < 16; i++) preset(i, 32'h0);

        // sw 0x10
        do_req(32'h10, 2'b10, 32'hDEADBEEF, 0);
        wait_done(1, 0);
        check("sw_addr",  {2'd0, bus.mem_addr}, 32'h4);
        check("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        idle(2);
        check("sw_mem", tb_mem[4], 32'hDEADBEEF);

        // sb 0x12
        preset(4, 32'h11223344);
        do_req(32'h12, 2'b00, 32'hFFFFFFAB, 0);
        wait_done(3, 0);
        check("sb_wdata", bus.mem_wdata, 32'h11AB3344);
        idle(2);
        check("sb_mem", tb_mem[4], 32'h11AB3344);
        check("sb_model", model_mem[4], 32'h11AB3344);

        // sb lane 3
        preset(4, 32'h11223344);
        do_req(32'h13, 2'b00, 32'h00000077, 0);
        wait_done(3, 0);
        idle(2);
        check("sb3_mem", tb_mem[4], 32'h77223344);

        // sh upper and lower halves
        preset(4, 32'h11223344);
        do_req(32'h12, 2'b01, 32'h0000BEEF, 0);
        wait_done(3, 0);
        check("sh_hi_wdata", bus.mem_wdata, 32'hBEEF3344);
        idle(2);
        check("sh_hi_mem", tb_mem[4], 32'hBEEF3344);
        preset(4, 32'h11223344);
        do_req(32'h10, 2'b01, 32'hCAFEBEEF, 0);
        wait_done(3, 0);
        idle(2);
        check("sh_lo_mem", tb_mem[4], 32'h1122BEEF);
        check("sh_lo_model", model_mem[4], 32'h1122BEEF);

        // sh into another word
        preset(9, 32'hA5A5A5A5);
        do_req(32'h24, 2'b01, 32'h00001234, 0);
        wait_done(3, 0);
        idle(2);
        check("sh_w9_mem", tb_mem[9], 32'hA5A51234);

        // misaligned / illegal
        do_req(32'h13, 2'b01, 32'h11111111, 0);
        wait_done(1, 1);
        idle(1);
        do_req(32'h12, 2'b10, 32'h22222222, 0);
        wait_done(1, 1);
        idle(1);
        do_req(32'h10, 2'b11, 32'h33333333, 0);
        wait_done(1, 1);
        idle(2);
        check("err_mem_untouched", tb_mem[4], 32'h1122BEEF);

        // back-to-back sb with valid held
        preset(4, 32'h11223344);
        do_req(32'h10, 2'b00, 32'h000000AB, 1);
        do_req(32'h11, 2'b00, 32'h000000CD, 0);
        wait_done(3, 0);
        idle(2);
        check("b2b_mem", tb_mem[4], 32'h1122CDAB);

        // reset while waiting for read data
        preset(4, 32'h11223344);
        do_req(32'h10, 2'b00, 32'h00000055, 0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_wr_en",  {31'd0, bus.mem_wr_en}, 32'd0);
        check("abort_done",   {31'd0, bus.done}, 32'd0);
        check("abort_addr",   {2'd0, bus.mem_addr}, 32'd0);
        check("abort_wdata",  bus.mem_wdata, 32'd0);
        Reset = 1'b0;
        #1 check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        idle(4);
        check("abort_mem", tb_mem[4], 32'h11223344);

        // unit still works after the abort
        do_req(32'h14, 2'b10, 32'h0BADF00D, 0);
        wait_done(1, 0);
        idle(3);
        check("post_abort_mem", tb_mem[5], 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
